// File: rtl/mcse_host_gpio_agent.sv
// Host-side GPIO agent for MCSE: answers the wakeup / reset / release handshakes
// and streams framed IP ID table entries on mcse_gpio_in[31:16] on request.
module mcse_host_gpio_agent #(
  parameter int unsigned N_IP         = 16,
  parameter int unsigned WORDS_PER_IP = 16,
  parameter logic [15:0] SOF_WORD     = 16'h7A7A,
  parameter logic [15:0] EOF_WORD     = 16'hB9B9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mcse_gpio_out,
  output logic [31:0] mcse_gpio_in,
  input  logic        ipid_wr_en,
  input  logic [7:0]  ipid_wr_addr,
  input  logic [15:0] ipid_wr_data,
  output logic        busy,
  output logic [4:0]  ip_count,
  output logic        all_sent,
  output logic        proto_err
);

  localparam int unsigned DEPTH = N_IP * WORDS_PER_IP;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCW   = $clog2(WORDS_PER_IP + 2);
  localparam logic [WCW-1:0] LAST_IDX = WCW'(WORDS_PER_IP + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DEASSERT, DONE} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] word_q, word_d;
  logic [4:0]     ip_count_q, ip_count_d;
  logic           proto_err_q, proto_err_d;
  logic [31:0]    gpio_in_q, gpio_in_d;
  logic           trig_prev_q;
  logic           trig, trig_rise, wr_ok;
  logic [AW-1:0]  rd_addr;
  logic [15:0]    table_mem [DEPTH];
  logic           unused_gpio_out;

  assign trig      = mcse_gpio_out[12];
  assign trig_rise = trig & ~trig_prev_q;
  assign unused_gpio_out = ^{mcse_gpio_out[31:13], mcse_gpio_out[11:7],
                             mcse_gpio_out[5], mcse_gpio_out[3:1]};

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    ip_count_d  = ip_count_q;
    proto_err_d = proto_err_q;
    gpio_in_d   = '0;
    wr_ok       = 1'b0;
    rd_addr     = '0;

    gpio_in_d[7] = gpio_in_q[7] | mcse_gpio_out[6];
    gpio_in_d[5] = gpio_in_q[5] | mcse_gpio_out[4];
    gpio_in_d[1] = mcse_gpio_out[0];

    if (ipid_wr_en) begin
      if ((32'(ipid_wr_addr) >= DEPTH) || (state_q == SEND) || (state_q == WAIT_DEASSERT))
        proto_err_d = 1'b1;
      else
        wr_ok = 1'b1;
    end

    // gpio_in is registered, so each cycle loads the word for the *next* slot
    unique case (state_q)
      IDLE: begin
        if (trig_rise && (32'(ip_count_q) < N_IP)) begin
          state_d          = SEND;
          word_d           = '0;
          gpio_in_d[13]    = 1'b1;
          gpio_in_d[31:16] = SOF_WORD;
        end
      end
      SEND: begin
        if (word_q == LAST_IDX) begin
          state_d = WAIT_DEASSERT;
        end else begin
          word_d        = word_q + 1'b1;
          gpio_in_d[13] = 1'b1;
          if (word_d == LAST_IDX) begin
            gpio_in_d[31:16] = EOF_WORD;
          end else begin
            rd_addr          = AW'(32'(ip_count_q) * WORDS_PER_IP + 32'(word_d) - 32'd1);
            gpio_in_d[31:16] = table_mem[rd_addr];
          end
        end
      end
      WAIT_DEASSERT: begin
        if (!trig) begin
          ip_count_d = ip_count_q + 5'd1;
          state_d    = (32'(ip_count_d) == N_IP) ? DONE : IDLE;
        end
      end
      DONE: begin
        if (trig) proto_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      ip_count_q  <= '0;
      proto_err_q <= 1'b0;
      gpio_in_q   <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      ip_count_q  <= ip_count_d;
      proto_err_q <= proto_err_d;
      gpio_in_q   <= gpio_in_d;
      trig_prev_q <= trig;
    end
  end

  // Table contents deliberately survive rst
  always_ff @(posedge clk) begin
    if (wr_ok) table_mem[AW'(ipid_wr_addr)] <= ipid_wr_data;
  end

  assign mcse_gpio_in = gpio_in_q;
  assign busy         = (state_q == SEND) || (state_q == WAIT_DEASSERT);
  assign ip_count     = ip_count_q;
  assign all_sent     = (state_q == DONE);
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mcse_host_gpio_agent.sv
// Scoreboard bench for mcse_host_gpio_agent: the driver queues expected frame
// words from a reference table; a negedge monitor pops and compares them.
module tb_mcse_host_gpio_agent;
  localparam int unsigned W   = 16;
  localparam int unsigned NIP = 16;
  localparam logic [15:0] SOF = 16'h7A7A;
  localparam logic [15:0] EOF = 16'hB9B9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_out, gpio_in;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, all_sent, proto_err;
  logic [4:0]  ip_count;

  always #5 clk = ~clk;

  mcse_host_gpio_agent #(
    .N_IP(NIP), .WORDS_PER_IP(W), .SOF_WORD(SOF), .EOF_WORD(EOF)
  ) dut (
    .clk(clk), .rst(rst), .mcse_gpio_out(gpio_out), .mcse_gpio_in(gpio_in),
    .ipid_wr_en(wr_en), .ipid_wr_addr(wr_addr), .ipid_wr_data(wr_data),
    .busy(busy), .ip_count(ip_count), .all_sent(all_sent), .proto_err(proto_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          model_frame = 0;
  int          run_len = 0;
  logic [15:0] ref_tab [256];
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every asserted frame-valid cycle must match the next queued word
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else begin
      check("unused_bits", gpio_in & ~32'hFFFF20A2, 32'd0);
      if (gpio_in[13]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", gpio_in[31:16], $time);
        end else begin
          check("frame_word", {16'd0, gpio_in[31:16]}, {16'd0, exp_q.pop_front()});
        end
        run_len++;
      end else begin
        if (run_len != 0) begin
          check("send_len", run_len, W + 2);
          check("post_frame_data", {16'd0, gpio_in[31:16]}, 32'd0);
        end
        run_len = 0;
      end
    end
  end

  task automatic push_frame();
    exp_q.push_back(SOF);
    for (int k = 0; k < int'(W); k++) exp_q.push_back(ref_tab[model_frame * int'(W) + k]);
    exp_q.push_back(EOF);
  endtask

  task automatic start_frame(input int hold, input bit do_wr, input logic [7:0] a,
                             input logic [15:0] d);
    @(negedge clk);
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d; ref_tab[a] = d;
    end
    gpio_out[12] = 1'b1;
    push_frame();
    @(negedge clk);
    wr_en = 1'b0;
    check("sof_latency", {15'd0, gpio_in[13], gpio_in[31:16]}, {15'd0, 1'b1, SOF});
    check("busy_in_send", {31'd0, busy}, 32'd1);
    repeat (hold - 1) @(negedge clk);
    gpio_out[12] = 1'b0;
  endtask

  task automatic finish_frame();
    int i = 0;
    while (busy && i < 80) begin
      @(negedge clk);
      i++;
    end
    check("frame_complete", {31'd0, busy}, 32'd0);
    model_frame++;
    check("ip_count", {27'd0, ip_count}, 32'(model_frame));
    check("all_sent", {31'd0, all_sent}, {31'd0, model_frame == int'(NIP)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gpio_in"}, gpio_in, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ip_count"}, {27'd0, ip_count}, 32'd0);
    check({tag, "_all_sent"}, {31'd0, all_sent}, 32'd0);
    check({tag, "_proto_err"}, {31'd0, proto_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] a;
    logic [15:0] d;
    rst = 1'b1; gpio_out = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 16'(i + 1); ref_tab[i] = 16'(i + 1);
    end
    @(negedge clk);
    wr_en = 1'b0;

    // frame 0: plain table contents
    start_frame(1, 1'b0, 8'd0, 16'd0);
    finish_frame();

    // reset-acknowledge follows gpio_out[0] with one cycle of delay
    @(negedge clk); gpio_out[0] = 1'b1;
    @(negedge clk); check("rst_ack_rise", {31'd0, gpio_in[1]}, 32'd1);
    repeat (4) @(negedge clk);
    gpio_out[0] = 1'b0;
    check("rst_ack_held", {31'd0, gpio_in[1]}, 32'd1);
    @(negedge clk); check("rst_ack_fall", {31'd0, gpio_in[1]}, 32'd0);

    // frame 1: write coincident with trigger, wakeup/release raised mid-frame
    start_frame(1, 1'b1, 8'(W), 16'($urandom));
    repeat (3) @(negedge clk);
    gpio_out[6] = 1'b1; gpio_out[4] = 1'b1;
    @(negedge clk);
    check("wakeup_set", {31'd0, gpio_in[7]}, 32'd1);
    check("release_set", {31'd0, gpio_in[5]}, 32'd1);
    gpio_out[6] = 1'b0; gpio_out[4] = 1'b0;
    repeat (3) @(negedge clk);
    check("wakeup_sticky", {31'd0, gpio_in[7]}, 32'd1);
    check("release_sticky", {31'd0, gpio_in[5]}, 32'd1);
    finish_frame();
    check("proto_err_clean", {31'd0, proto_err}, 32'd0);

    // frame 2: a write during SEND must be dropped and flagged
    start_frame(1, 1'b0, 8'd0, 16'd0);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'(2 * W + 5); wr_data = 16'hDEAD;
    @(negedge clk);
    wr_en = 1'b0;
    check("proto_err_wr_send", {31'd0, proto_err}, 32'd1);
    finish_frame();

    // frame 3: asynchronous reset at word 9 aborts the frame
    start_frame(1, 1'b0, 8'd0, 16'd0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("abort");
    exp_q.delete();
    model_frame = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // full boot: 16 frames with random trigger widths and random table edits
    for (int f = 0; f < int'(NIP); f++) begin
      if (f > 0) begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          a = 8'($urandom_range(239, 16));
          d = 16'($urandom);
          wr_en = 1'b1; wr_addr = a; wr_data = d; ref_tab[a] = d;
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      start_frame(int'($urandom_range(25, 1)), 1'b0, 8'd0, 16'd0);
      finish_frame();
    end
    check("proto_err_after_boot", {31'd0, proto_err}, 32'd0);

    // 17th trigger in DONE: ignored, flagged
    @(negedge clk); gpio_out[12] = 1'b1;
    repeat (25) @(negedge clk);
    check("done_no_send", {31'd0, busy}, 32'd0);
    check("done_proto_err", {31'd0, proto_err}, 32'd1);
    check("done_all_sent", {31'd0, all_sent}, 32'd1);
    check("done_ip_count", {27'd0, ip_count}, 32'(NIP));
    gpio_out[12] = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcse_host_gpio_agent.md
MCSE_HOST_GPIO_AGENT -- requirements
Module: mcse_host_gpio_agent

Interface
REQ-001 SHALL have parameter N_IP, default 16, meaning number of IP ID frames served per boot.
REQ-002 SHALL have parameter WORDS_PER_IP, default 16, meaning payload words per frame.
REQ-003 SHALL have parameter SOF_WORD, default 16'h7A7A, meaning the frame start marker.
REQ-004 SHALL have parameter EOF_WORD, default 16'hB9B9, meaning the frame end marker.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port mcse_gpio_out, input, 32, the MCSE gpio_out bus being observed.
REQ-008 SHALL have port mcse_gpio_in, output, 32, the bus driving MCSE gpio_in.
REQ-009 SHALL have port ipid_wr_en, input, 1, the IP ID table write strobe.
REQ-010 SHALL have port ipid_wr_addr, input, 8, the table word index, 0..N_IP*WORDS_PER_IP-1.
REQ-011 SHALL have port ipid_wr_data, input, 16, the table write data.
REQ-012 SHALL have port busy, output, 1, high in SEND or WAIT_DEASSERT.
REQ-013 SHALL have port ip_count, output, 5, the number of frames completed.
REQ-014 SHALL have port all_sent, output, 1, high once N_IP frames have completed.
REQ-015 SHALL have port proto_err, output, 1, sticky protocol-error flag.

Function
REQ-016 SHALL register every mcse_gpio_in bit; bits not listed below SHALL be driven 0.
REQ-017 Bus wakeup: SHALL set mcse_gpio_in[7] on the cycle after mcse_gpio_out[6]==1 is sampled; bit is sticky until rst.
REQ-018 Reset ack: SHALL drive mcse_gpio_in[1]=1 on the cycle after mcse_gpio_out[0]==1 is sampled; SHALL clear it on the cycle after mcse_gpio_out[0]==0 is sampled.
REQ-019 Operation release: SHALL set mcse_gpio_in[5] on the cycle after mcse_gpio_out[4]==1 is sampled; bit is sticky until rst.
REQ-020 IP ID FSM states SHALL be IDLE, SEND, WAIT_DEASSERT and DONE.
REQ-021 IDLE->SEND SHALL occur when mcse_gpio_out[12]==1 is sampled and ip_count<N_IP; word counter is cleared to 0.
REQ-022 SEND SHALL last exactly WORDS_PER_IP+2 cycles (18 by default) with mcse_gpio_in[13]=1 throughout.
REQ-023 SEND word order on mcse_gpio_in[31:16]: SOF_WORD, then table[ip_count*WORDS_PER_IP+k] for k=0..WORDS_PER_IP-1, then EOF_WORD.
REQ-024 Latency: SOF_WORD SHALL appear in the cycle after the trigger sample, and words SHALL be consecutive with no gaps.
REQ-025 After the EOF cycle the FSM SHALL enter WAIT_DEASSERT with mcse_gpio_in[13]=0 and [31:16]=0.
REQ-026 WAIT_DEASSERT SHALL exit on a sampled mcse_gpio_out[12]==0; ip_count SHALL increment by 1 on exit, then go to DONE if ip_count==N_IP, else to IDLE.
REQ-027 DONE SHALL set all_sent=1 and hold; any later mcse_gpio_out[12]==1 SHALL be ignored and SHALL set proto_err.
REQ-028 Table writes SHALL be accepted in IDLE and DONE only; a write in SEND or WAIT_DEASSERT SHALL be dropped and SHALL set proto_err.
REQ-029 An out-of-range ipid_wr_addr SHALL be dropped and SHALL set proto_err.
REQ-030 Trigger sampled high in the same cycle as a table write in IDLE: the write SHALL complete first and the frame SHALL use the new data.
REQ-031 A trigger still high on IDLE re-entry SHALL NOT start a new frame; a 0->1 edge SHALL be required (the edge detector is armed in WAIT_DEASSERT).
REQ-032 The handshakes in REQ-017 to REQ-019 SHALL operate concurrently with, and independently of, the IP ID FSM.

Reset
REQ-033 While rst is high, mcse_gpio_in=0, FSM=IDLE, ip_count=0, busy=0, all_sent=0, proto_err=0, and the trigger edge detector SHALL be cleared; table contents are unchanged.
REQ-034 rst asserted mid-SEND SHALL abort the frame immediately (asynchronously), with no EOF emitted.

Verification
REQ-035 Load table[i]=i+1 for i=0..255, pulse trigger -> 18 cycles: 7A7A, 0001..0010, B9B9, with [13]=1; then [13]=0.
REQ-036 Run 16 trigger/deassert rounds -> frame 15 carries 00F1..0100; ip_count=16; all_sent=1; a 17th trigger sets proto_err=1 with no SEND.
REQ-037 Set gpio_out[0]=1 for 5 cycles, then 0 -> [1] goes high 1 cycle after the rise and low 1 cycle after the fall.
REQ-038 Raise gpio_out[6] and gpio_out[4] during a frame -> [7] and [5] set 1 cycle later, stay set, and frame words are unaffected.
REQ-039 Assert rst at word 9 of frame 3 -> all outputs 0 at once; after release the next trigger sends frame 0 (SOF, 0001..).
REQ-040 Write during SEND -> dropped, proto_err=1, and the frame data is unchanged.
